gray_capture: RTL and testbench

// - Upstream capture stage for Gray-to-binary conversion: samples an asynchronous Gray-coded bus
//   (position encoder, foreign-domain counter), synchronises it and checks single-bit steps.
// - Each legal change is queued in a 2-entry valid/ready buffer; downstream prefix-XOR decodes GO.
// - Multi-bit jumps are flagged as errors and overflow is reported as a sticky flag.

---
 rtl/gray_capture.sv | 230 +++++++++++++++++++++++
 tb/tb_gray_capture.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_capture.sv
`default_nettype none
// ============================================================================
// Module   : gray_capture
// Purpose  : Capture stage for an asynchronous Gray-coded bus, such as a
//            position encoder or a counter in another clock domain. The
//            input passes through a flop synchroniser. The synchronised word
//            is compared with the last accepted code. A single-bit change is
//            a legal step and is queued in a 2-entry valid/ready buffer. A
//            change of two or more bits is reported as an error and
//            re-synchronises the reference code.
//
// Parameters
//   WIDTH        Gray word width (>= 2)
//   SYNC_STAGES  synchroniser depth (>= 2)
//
// Ports
//   CLK     in   1      clock, all state updates on the rising edge
//   RSTN    in   1      asynchronous active-low reset
//   GI      in   WIDTH  asynchronous Gray input, read only via the synchroniser
//   CLR     in   1      synchronous clear of OVF and ERRCNT
//   GO      out  WIDTH  Gray value of the head buffer entry
//   VALID   out  1      head entry present
//   READY   in   1      downstream takes the head entry when VALID & READY
//   ERR     out  1      one-cycle pulse on an illegal multi-bit step
//   ERRCNT  out  8      saturating count of ERR pulses
//   OVF     out  1      sticky flag: a legal step was dropped, buffer full
//   DIR     out  1      (GRAY_CAPTURE_DIR_EN only) head entry counts upward
//
// Configuration
//   GRAY_CAPTURE_DIR_EN  when defined, each entry also stores a direction
//                        bit. The bit is 1 when bin(new) == bin(old) + 1.
//
// Revision : 1.0  initial release
// ============================================================================
module gray_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] GI,
  input  logic             CLR,
  output logic [WIDTH-1:0] GO,
  output logic             VALID,
  input  logic             READY,
  output logic             ERR,
  output logic [7:0]       ERRCNT,
`ifdef GRAY_CAPTURE_DIR_EN
  output logic             DIR,
`endif
  output logic             OVF
);

  // Each buffer entry is the Gray word. With direction enabled, the
  // direction bit is stored in the MSB above the Gray word.
`ifdef GRAY_CAPTURE_DIR_EN
  localparam int c_ew = WIDTH + 1;
`else
  localparam int c_ew = WIDTH;
`endif

  localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
  localparam logic [7:0]       c_cnt_max = 8'hFF;

  // --------------------------------------------------------------------------
  // Synchroniser: stage 0 samples GI. The last stage is the safe word GS.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  w_gs;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], GI};
    end
  end

  assign w_gs = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Step classification against the last accepted code.
  // A one-hot difference is a legal step. Clearing the lowest set bit of
  // the difference leaves zero exactly when a single bit changed.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] glast_q, glast_d;
  logic [WIDTH-1:0] w_diff;
  logic             w_any;
  logic             w_step;
  logic             w_multi;

  assign w_diff  = w_gs ^ glast_q;
  assign w_any   = |w_diff;
  assign w_step  = w_any && ((w_diff & (w_diff - c_one)) == '0);
  assign w_multi = w_any && !w_step;

  // Any change moves the reference. After an error the reference is
  // re-synchronised, so the next comparison is against the new code.
  assign glast_d = w_any ? w_gs : glast_q;

  // --------------------------------------------------------------------------
  // Direction of a legal step (optional)
  // --------------------------------------------------------------------------
  logic [c_ew-1:0] w_entry;

`ifdef GRAY_CAPTURE_DIR_EN
  // Serial prefix XOR from the MSB down.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] w_bin_new;
  logic [WIDTH-1:0] w_bin_inc;
  logic             w_dir_up;

  assign w_bin_new = gray2bin(w_gs);
  assign w_bin_inc = gray2bin(glast_q) + c_one;   // wraps mod 2^WIDTH
  assign w_dir_up  = (w_bin_new == w_bin_inc);
  assign w_entry   = {w_dir_up, w_gs};
`else
  assign w_entry   = w_gs;
`endif

  // --------------------------------------------------------------------------
  // Two-entry in-order buffer. The head register drives GO/VALID directly.
  // The pop is applied first. The push then fills the first slot that is
  // free after the pop, so push + pop on a full buffer loses nothing.
  // --------------------------------------------------------------------------
  logic [c_ew-1:0] head_q, head_d;
  logic            headv_q, headv_d;
  logic [c_ew-1:0] tail_q, tail_d;
  logic            tailv_q, tailv_d;
  logic            w_pop;
  logic            w_drop;

  assign w_pop = headv_q && READY;

  always_comb begin
    head_d  = head_q;
    headv_d = headv_q;
    tail_d  = tail_q;
    tailv_d = tailv_q;
    w_drop  = 1'b0;

    if (w_pop) begin
      head_d  = tail_q;
      headv_d = tailv_q;
      tailv_d = 1'b0;
    end

    if (w_step) begin
      if (!headv_d) begin
        head_d  = w_entry;
        headv_d = 1'b1;
      end else if (!tailv_d) begin
        tail_d  = w_entry;
        tailv_d = 1'b1;
      end else begin
        w_drop  = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Status: error pulse, saturating error count, sticky overflow.
  // A new error or overflow takes priority over CLR in the same cycle.
  // --------------------------------------------------------------------------
  logic       err_q, err_d;
  logic [7:0] errcnt_q, errcnt_d;
  logic       ovf_q, ovf_d;

  always_comb begin
    err_d    = w_multi;
    errcnt_d = errcnt_q;
    if (w_multi) begin
      if (CLR) begin
        errcnt_d = 8'd1;
      end else if (errcnt_q != c_cnt_max) begin
        errcnt_d = errcnt_q + 8'd1;
      end
    end else if (CLR) begin
      errcnt_d = 8'd0;
    end
    ovf_d = w_drop || (ovf_q && !CLR);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      glast_q  <= '0;
      head_q   <= '0;
      headv_q  <= 1'b0;
      tail_q   <= '0;
      tailv_q  <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= 8'd0;
      ovf_q    <= 1'b0;
    end else begin
      glast_q  <= glast_d;
      head_q   <= head_d;
      headv_q  <= headv_d;
      tail_q   <= tail_d;
      tailv_q  <= tailv_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign GO     = head_q[WIDTH-1:0];
  assign VALID  = headv_q;
  assign ERR    = err_q;
  assign ERRCNT = errcnt_q;
  assign OVF    = ovf_q;
`ifdef GRAY_CAPTURE_DIR_EN
  assign DIR    = head_q[WIDTH];
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_capture
// Purpose  : Self-checking bench for gray_capture (WIDTH=4, SYNC_STAGES=2).
//            It runs a table of directed vectors, hand-written corner
//            sequences and randomized stimulus. All of it is checked against
//            a cycle-level reference model built from queues.
// Revision : 1.0  initial release
// ============================================================================
module tb_gray_capture;

  localparam int W = 4;
  localparam int S = 2;

  logic         CLK   = 1'b0;
  logic         RSTN  = 1'b0;
  logic         CLR   = 1'b0;
  logic         READY = 1'b0;
  logic [W-1:0] GI    = '0;
  logic [W-1:0] GO;
  logic         VALID;
  logic         ERR;
  logic         OVF;
  logic [7:0]   ERRCNT;
`ifdef GRAY_CAPTURE_DIR_EN
  logic         DIR;
`endif

  gray_capture #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .GI     (GI),
    .CLR    (CLR),
    .GO     (GO),
    .VALID  (VALID),
    .READY  (READY),
    .ERR    (ERR),
    .ERRCNT (ERRCNT),
`ifdef GRAY_CAPTURE_DIR_EN
    .DIR    (DIR),
`endif
    .OVF    (OVF)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [W-1:0] g;
    logic         d;
  } ent_t;

  logic [W-1:0] m_sync [S];
  logic [W-1:0] m_glast;
  ent_t         m_q [$];
  logic         m_err;
  logic         m_ovf;
  int           m_cnt;

  // Binary value of a Gray code, found by searching the reflected-code table.
  function automatic int bin_of(input logic [W-1:0] g);
    for (int b = 0; b < (1 << W); b++) begin
      if (W'(b ^ (b >> 1)) == g) return b;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_sync[i] = '0;
    m_glast = '0;
    m_q.delete();
    m_err = 1'b0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  // Advance the model by one clock edge, using the inputs seen at that edge.
  task automatic model_tick();
    logic [W-1:0] gs;
    int           n;
    bit           drop;
    ent_t         e;
    gs   = m_sync[S-1];
    n    = $countones(gs ^ m_glast);
    drop = 1'b0;
    if (m_q.size() > 0 && READY) m_q.delete(0);
    m_err = 1'b0;
    if (n == 1) begin
      e.g = gs;
      e.d = (bin_of(gs) == (bin_of(m_glast) + 1) % (1 << W));
      if (m_q.size() < 2) m_q.push_back(e);
      else                drop = 1'b1;
    end else if (n >= 2) begin
      m_err = 1'b1;
    end
    if (n > 0) m_glast = gs;
    if (m_err)    m_cnt = CLR ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    else if (CLR) m_cnt = 0;
    m_ovf = drop | (m_ovf & !CLR);
    for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = GI;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("m_valid", VALID, 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("m_go", GO, m_q[0].g);
`ifdef GRAY_CAPTURE_DIR_EN
      check("m_dir", DIR, m_q[0].d);
`endif
    end
    check("m_err", ERR, m_err);
    check("m_errcnt", ERRCNT, m_cnt);
    check("m_ovf", OVF, m_ovf);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_tick();
    #1;
    compare_model();
  endtask

  // --------------------------------------------------------- vector table
  typedef struct {
    logic [W-1:0] gi;
    logic         rdy;
    logic         clr;
    int           n;      // clock edges to apply these inputs
    logic         ev;     // expected VALID after the last edge
    logic [W-1:0] ego;    // expected GO (checked when ev)
    logic         eerr;
    logic [7:0]   ecnt;
    logic         eovf;
  } vec_t;

  vec_t vq [$];

  initial begin
    int r;
    logic [W-1:0] g;

    //            gi     rdy clr n  ev go      err cnt   ovf
    vq.push_back('{4'b0001, 1, 0, 2, 0, 4'b0000, 0, 8'd0, 0});
    vq.push_back('{4'b0001, 1, 0, 1, 1, 4'b0001, 0, 8'd0, 0});  // VALID at cycle 3
    vq.push_back('{4'b0001, 1, 0, 1, 0, 4'b0000, 0, 8'd0, 0});  // popped, 1 cycle
    vq.push_back('{4'b0000, 1, 0, 3, 1, 4'b0000, 0, 8'd0, 0});
    vq.push_back('{4'b0000, 1, 0, 1, 0, 4'b0000, 0, 8'd0, 0});
    vq.push_back('{4'b0011, 1, 0, 3, 0, 4'b0000, 1, 8'd1, 0});  // 2-bit jump
    vq.push_back('{4'b0011, 1, 0, 1, 0, 4'b0000, 0, 8'd1, 0});  // pulse ends
    vq.push_back('{4'b0010, 1, 0, 3, 1, 4'b0010, 0, 8'd1, 0});  // legal vs 0011
    vq.push_back('{4'b0010, 1, 0, 1, 0, 4'b0000, 0, 8'd1, 0});
    vq.push_back('{4'b0000, 1, 0, 4, 0, 4'b0000, 0, 8'd1, 0});
    vq.push_back('{4'b0001, 0, 0, 3, 1, 4'b0001, 0, 8'd1, 0});  // stalled
    vq.push_back('{4'b0011, 0, 0, 3, 1, 4'b0001, 0, 8'd1, 0});  // GO held
    vq.push_back('{4'b0010, 0, 0, 3, 1, 4'b0001, 0, 8'd1, 1});  // dropped
    vq.push_back('{4'b0010, 1, 0, 1, 1, 4'b0011, 0, 8'd1, 1});  // in order
    vq.push_back('{4'b0010, 1, 0, 1, 0, 4'b0000, 0, 8'd1, 1});
    vq.push_back('{4'b0010, 1, 1, 1, 0, 4'b0000, 0, 8'd0, 0});  // CLR
    vq.push_back('{4'b0110, 0, 0, 3, 1, 4'b0110, 0, 8'd0, 0});
    vq.push_back('{4'b0111, 0, 0, 3, 1, 4'b0110, 0, 8'd0, 0});  // full
    vq.push_back('{4'b0101, 0, 0, 2, 1, 4'b0110, 0, 8'd0, 0});
    vq.push_back('{4'b0101, 1, 0, 1, 1, 4'b0111, 0, 8'd0, 0});  // push+pop full
    vq.push_back('{4'b0101, 1, 0, 1, 1, 4'b0101, 0, 8'd0, 0});
    vq.push_back('{4'b0101, 1, 0, 1, 0, 4'b0000, 0, 8'd0, 0});
    vq.push_back('{4'b0100, 1, 0, 4, 0, 4'b0000, 0, 8'd0, 0});
    vq.push_back('{4'b1100, 1, 0, 4, 0, 4'b0000, 0, 8'd0, 0});
    vq.push_back('{4'b1000, 1, 0, 3, 1, 4'b1000, 0, 8'd0, 0});
    vq.push_back('{4'b0000, 1, 0, 3, 1, 4'b0000, 0, 8'd0, 0});  // wrap max->0
    vq.push_back('{4'b0000, 1, 0, 1, 0, 4'b0000, 0, 8'd0, 0});

    // ------------------------------------------------------------ reset
    model_reset();
    #12;
    check("rst_valid", VALID, 0);
    check("rst_go", GO, 0);
    check("rst_err", ERR, 0);
    check("rst_errcnt", ERRCNT, 0);
    check("rst_ovf", OVF, 0);
    @(negedge CLK);
    RSTN = 1'b1;

    // ------------------------------------------------------- table vectors
    foreach (vq[i]) begin
      GI    = vq[i].gi;
      READY = vq[i].rdy;
      CLR   = vq[i].clr;
      repeat (vq[i].n) tick();
      check($sformatf("vec%0d_valid", i), VALID, vq[i].ev);
      if (vq[i].ev) check($sformatf("vec%0d_go", i), GO, vq[i].ego);
      check($sformatf("vec%0d_err", i), ERR, vq[i].eerr);
      check($sformatf("vec%0d_errcnt", i), ERRCNT, vq[i].ecnt);
      check($sformatf("vec%0d_ovf", i), OVF, vq[i].eovf);
    end

    // ----------------------------------- CLR and overflow in the same cycle
    READY = 1'b0;
    GI = 4'b0001; repeat (3) tick();
    GI = 4'b0011; repeat (3) tick();
    GI = 4'b0010; repeat (2) tick();
    CLR = 1'b1;   tick();
    check("clr_ovf_same", OVF, 1);
    tick();
    check("clr_ovf_after", OVF, 0);
    CLR = 1'b0;
    READY = 1'b1;
    repeat (3) tick();
    check("drain_valid", VALID, 0);

    // ------------------------------------------- error count saturation
    for (int i = 0; i < 300; i++) begin
      GI = (i % 2 == 1) ? 4'b0010 : 4'b1101;
      tick();
    end
    repeat (3) tick();
    check("errcnt_sat", ERRCNT, 255);

    // ------------------------------------- CLR and error in the same cycle
    GI = GI ^ 4'b0110;
    repeat (2) tick();
    CLR = 1'b1; tick();
    check("clr_err_cnt", ERRCNT, 1);
    check("clr_err_pulse", ERR, 1);
    CLR = 1'b0;

    // ---------------------------------------- reset with an entry queued
    READY = 1'b0;
    GI = m_glast ^ 4'b0100;
    repeat (3) tick();
    check("prerst_valid", VALID, 1);
    #3;
    RSTN = 1'b0;
    #1;
    check("midrst_valid", VALID, 0);
    check("midrst_go", GO, 0);
    check("midrst_errcnt", ERRCNT, 0);
    check("midrst_err", ERR, 0);
    check("midrst_ovf", OVF, 0);
    model_reset();
    GI = 4'b0011;
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (3) tick();
    check("postrst_err", ERR, 1);
    check("postrst_valid", VALID, 0);

    // --------------------------------------------------------- randomized
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      g = GI;
      if (r < 6)       g = g ^ (4'b0001 << $urandom_range(0, 3));
      else if (r == 6) g = 4'($urandom);
      GI    = g;
      READY = ($urandom_range(0, 3) != 0);
      CLR   = ($urandom_range(0, 24) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
